// File: rtl/frank_pkg.sv
// Shared jump-unit definitions: branch opcode encodings and flag bit positions.
package frank_pkg;

  typedef enum logic [2:0] {
    OP_GOTO   = 3'b000,
    OP_GTIFZ  = 3'b001,
    OP_GTIFN  = 3'b010,
    OP_GTIFC  = 3'b011,
    OP_GTIFNZ = 3'b100,
    OP_GTIFNC = 3'b101,
    OP_CALL   = 3'b110,
    OP_RET    = 3'b111
  } br_op_e;

  localparam int FLAG_W = 3;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

endpackage

// File: rtl/return_stack.sv
// Return-address stack for CALL/RET. Push is ignored when full and pop is
// ignored when empty, so the pointer never wraps. Contents are not reset.
module return_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [ADDR_W-1:0]                  din,
  output logic [ADDR_W-1:0]                  top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               full,
  output logic                               empty
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W   = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  top_idx;

  assign full    = (depth == DEPTH_W'(STACK_DEPTH));
  assign empty   = (depth == '0);
  assign wr_idx  = IDX_W'(depth);
  assign top_idx = IDX_W'(depth - DEPTH_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  // Storage write: the new entry lands in the slot just above the current top
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= din;
    end
  end

  // Occupancy counter; reset wins over any pending push or pop
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (push && !full) begin
      depth <= depth + DEPTH_W'(1);
    end else if (pop && !empty) begin
      depth <= depth - DEPTH_W'(1);
    end
  end

endmodule

// File: rtl/jump_unit.sv
// Jump unit: flag register, zero-latency branch condition decode and a
// return stack for CALL/RET, with sticky overflow/underflow indicators.
module jump_unit
  import frank_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flag_we,
  input  logic [FLAG_W-1:0]                  flags_in,
  input  logic                               br_valid,
  input  logic [2:0]                         br_op,
  input  logic [ADDR_W-1:0]                  target,
  input  logic [ADDR_W-1:0]                  pc_ret,
  output logic                               jump,
  output logic [ADDR_W-1:0]                  jump_addr,
  output logic [FLAG_W-1:0]                  flags_q,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               ovf,
  output logic                               unf
);

  logic              stk_full;
  logic              stk_empty;
  logic [ADDR_W-1:0] stk_top;
  logic              do_push;
  logic              do_pop;
  logic              set_ovf;
  logic              set_unf;

  return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_push),
    .pop   (do_pop),
    .din   (pc_ret),
    .top   (stk_top),
    .depth (depth),
    .full  (stk_full),
    .empty (stk_empty)
  );

  // Branch decode against the registered flags; address is forced to 0 when not jumping
  always_comb begin
    jump      = 1'b0;
    jump_addr = '0;
    do_push   = 1'b0;
    do_pop    = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (br_valid) begin
      case (br_op)
        OP_GOTO:   jump = 1'b1;
        OP_GTIFZ:  jump = flags_q[FLAG_Z];
        OP_GTIFN:  jump = flags_q[FLAG_N];
        OP_GTIFC:  jump = flags_q[FLAG_C];
        OP_GTIFNZ: jump = !flags_q[FLAG_Z];
        OP_GTIFNC: jump = !flags_q[FLAG_C];
        OP_CALL: begin
          jump    = 1'b1;
          do_push = !stk_full;
          set_ovf = stk_full;
        end
        OP_RET: begin
          jump    = !stk_empty;
          do_pop  = !stk_empty;
          set_unf = stk_empty;
        end
        default: jump = 1'b0;
      endcase
      if (jump) begin
        jump_addr = (br_op == OP_RET) ? stk_top : target;
      end
    end
  end

  // Flag register: loads only on flag_we, untouched by branches
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= flags_in;
    end
  end

  // Sticky stack error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (set_ovf) ovf <= 1'b1;
      if (set_unf) unf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_unit.sv
// Self-checking bench for jump_unit: a vector table for the default
// configuration plus a hand-written sequence for a 12-bit, 2-deep instance.
module tb_jump_unit;
  import frank_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default instance (ADDR_W=8, STACK_DEPTH=4)
  logic       rst, flag_we, br_valid;
  logic [2:0] flags_in, br_op;
  logic [7:0] target, pc_ret;
  logic       jump, ovf, unf;
  logic [7:0] jump_addr;
  logic [2:0] flags_q;
  logic [2:0] depth;

  jump_unit dut (
    .clk(clk), .rst(rst), .flag_we(flag_we), .flags_in(flags_in),
    .br_valid(br_valid), .br_op(br_op), .target(target), .pc_ret(pc_ret),
    .jump(jump), .jump_addr(jump_addr), .flags_q(flags_q), .depth(depth),
    .ovf(ovf), .unf(unf)
  );

  // Wide-address, shallow-stack instance
  logic        b_rst, b_flag_we, b_br_valid;
  logic [2:0]  b_flags_in, b_br_op;
  logic [11:0] b_target, b_pc_ret;
  logic        b_jump, b_ovf, b_unf;
  logic [11:0] b_jump_addr;
  logic [2:0]  b_flags_q;
  logic [1:0]  b_depth;

  jump_unit #(.ADDR_W(12), .STACK_DEPTH(2)) dut_b (
    .clk(clk), .rst(b_rst), .flag_we(b_flag_we), .flags_in(b_flags_in),
    .br_valid(b_br_valid), .br_op(b_br_op), .target(b_target), .pc_ret(b_pc_ret),
    .jump(b_jump), .jump_addr(b_jump_addr), .flags_q(b_flags_q), .depth(b_depth),
    .ovf(b_ovf), .unf(b_unf)
  );

  // Expected state fields describe the DUT before the edge that consumes the inputs
  typedef struct {
    logic       rst;
    logic       fwe;
    logic [2:0] fin;
    logic       bv;
    logic [2:0] op;
    logic [7:0] tgt;
    logic [7:0] pcr;
    logic       ej;
    logic [7:0] ea;
    logic [2:0] ef;
    logic [2:0] ed;
    logic       eo;
    logic       eu;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst      = v.rst;
    flag_we  = v.fwe;
    flags_in = v.fin;
    br_valid = v.bv;
    br_op    = v.op;
    target   = v.tgt;
    pc_ret   = v.pcr;
  endtask

  task automatic addVec(input logic r, input logic fw, input logic [2:0] fi, input logic bv,
                        input logic [2:0] op, input logic [7:0] tg, input logic [7:0] pr,
                        input logic ej, input logic [7:0] ea, input logic [2:0] ef,
                        input logic [2:0] ed, input logic eo, input logic eu);
    vec_t v;
    v = '{r, fw, fi, bv, op, tg, pr, ej, ea, ef, ed, eo, eu};
    vecs.push_back(v);
  endtask

  task automatic driveB(input logic r, input logic bv, input logic [2:0] op,
                        input logic [11:0] tg, input logic [11:0] pr);
    b_rst      = r;
    b_flag_we  = 1'b0;
    b_flags_in = 3'b000;
    b_br_valid = bv;
    b_br_op    = op;
    b_target   = tg;
    b_pc_ret   = pr;
  endtask

  initial begin
    //     rst fwe fin     bv op         tgt    pcr    | ej ea     ef      ed  ovf unf
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 0);
    addVec(0, 1, 3'b001, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFZ,  8'h3C, 8'h00,  1, 8'h3C, 3'b001, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFNZ, 8'h3C, 8'h00,  0, 8'h00, 3'b001, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GOTO,   8'h55, 8'h00,  1, 8'h55, 3'b001, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFN,  8'h11, 8'h00,  0, 8'h00, 3'b001, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFNC, 8'h22, 8'h00,  1, 8'h22, 3'b001, 3'd0, 0, 0);
    addVec(0, 1, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b001, 3'd0, 0, 0);
    addVec(0, 1, 3'b100, 1, OP_GTIFC,  8'h10, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFC,  8'h10, 8'h00,  1, 8'h10, 3'b100, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFNC, 8'h22, 8'h00,  0, 8'h00, 3'b100, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFZ,  8'h22, 8'h00,  0, 8'h00, 3'b100, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_GTIFNZ, 8'h33, 8'h00,  1, 8'h33, 3'b100, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h40, 8'h05,  1, 8'h40, 3'b100, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h41, 8'h06,  1, 8'h41, 3'b100, 3'd1, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h42, 8'h07,  1, 8'h42, 3'b100, 3'd2, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h43, 8'h08,  1, 8'h43, 3'b100, 3'd3, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h20, 8'h09,  1, 8'h20, 3'b100, 3'd4, 0, 0);
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b100, 3'd4, 1, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  1, 8'h08, 3'b100, 3'd4, 1, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  1, 8'h07, 3'b100, 3'd3, 1, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  1, 8'h06, 3'b100, 3'd2, 1, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  1, 8'h05, 3'b100, 3'd1, 1, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  0, 8'h00, 3'b100, 3'd0, 1, 0);
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b100, 3'd0, 1, 1);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h50, 8'h0A,  1, 8'h50, 3'b100, 3'd0, 1, 1);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  1, 8'h0A, 3'b100, 3'd1, 1, 1);
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b100, 3'd0, 1, 1);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h60, 8'h0B,  1, 8'h60, 3'b100, 3'd0, 1, 1);
    addVec(0, 0, 3'b000, 1, OP_CALL,   8'h61, 8'h0C,  1, 8'h61, 3'b100, 3'd1, 1, 1);
    addVec(1, 1, 3'b111, 1, OP_RET,    8'h99, 8'h00,  1, 8'h0C, 3'b100, 3'd2, 1, 1);
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 1, OP_RET,    8'h99, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 0);
    addVec(0, 0, 3'b000, 0, OP_GOTO,   8'h00, 8'h00,  0, 8'h00, 3'b000, 3'd0, 0, 1);

    // Reset both instances
    rst = 1'b1; flag_we = 1'b0; flags_in = 3'b000; br_valid = 1'b0;
    br_op = 3'b000; target = 8'h00; pc_ret = 8'h00;
    driveB(1'b1, 1'b0, OP_GOTO, 12'h000, 12'h000);
    @(negedge clk);
    @(negedge clk);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d jump", i),      32'(jump),      32'(vecs[i].ej));
      checkOutput($sformatf("v%0d jump_addr", i), 32'(jump_addr), 32'(vecs[i].ea));
      checkOutput($sformatf("v%0d flags_q", i),   32'(flags_q),   32'(vecs[i].ef));
      checkOutput($sformatf("v%0d depth", i),     32'(depth),     32'(vecs[i].ed));
      checkOutput($sformatf("v%0d ovf", i),       32'(ovf),       32'(vecs[i].eo));
      checkOutput($sformatf("v%0d unf", i),       32'(unf),       32'(vecs[i].eu));
      @(negedge clk);
    end

    // 12-bit / 2-deep instance: CALL, RET, GOTO to all-ones, then overflow
    driveB(1'b0, 1'b1, OP_CALL, 12'h123, 12'hABC);
    #1;
    checkOutput("b call jump", 32'(b_jump), 32'd1);
    checkOutput("b call addr", 32'(b_jump_addr), 32'h123);
    checkOutput("b reset depth", 32'(b_depth), 32'd0);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_RET, 12'h000, 12'h000);
    #1;
    checkOutput("b ret depth", 32'(b_depth), 32'd1);
    checkOutput("b ret addr", 32'(b_jump_addr), 32'hABC);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_GOTO, 12'hFFF, 12'h000);
    #1;
    checkOutput("b goto addr", 32'(b_jump_addr), 32'hFFF);
    checkOutput("b goto depth", 32'(b_depth), 32'd0);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_CALL, 12'h100, 12'h111);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_CALL, 12'h200, 12'h222);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_CALL, 12'h333, 12'h444);
    #1;
    checkOutput("b full call jump", 32'(b_jump), 32'd1);
    checkOutput("b full call addr", 32'(b_jump_addr), 32'h333);
    checkOutput("b full depth", 32'(b_depth), 32'd2);
    @(negedge clk);
    driveB(1'b0, 1'b1, OP_RET, 12'h000, 12'h000);
    #1;
    checkOutput("b ovf", 32'(b_ovf), 32'd1);
    checkOutput("b depth held", 32'(b_depth), 32'd2);
    checkOutput("b ret top", 32'(b_jump_addr), 32'h222);
    @(negedge clk);
    driveB(1'b0, 1'b0, OP_GOTO, 12'h000, 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
